// File: rtl/mdrv_rr_if.sv
// rtl/mdrv_rr_if.sv - memory write port bundle between mdrv_rr and a single-port memory
//
// Signals:
//   we   write strobe, driven by the sequencer
//   ai   write address, driven by the sequencer
//   ch   id of the channel that owns the current beat, driven by the sequencer
//   rdy  memory accepts the current beat when we && rdy, driven by the memory
// Modports: master (sequencer side), slave (memory side).
interface mdrv_rr_if #(
    parameter int NCH = 4,
    parameter int AW  = 8
);
    localparam int CW = $clog2(NCH);

    logic          we;
    logic [AW-1:0] ai;
    logic [CW-1:0] ch;
    logic          rdy;

    modport master (output we, output ai, output ch, input rdy);
    modport slave  (input we, input ai, input ch, output rdy);
endinterface

// File: rtl/mdrv_rr.sv
// rtl/mdrv_rr.sv - NCH burst address channels merged round-robin onto one registered write port
//
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   start  per-channel start pulse, honoured only while that channel is idle
//   mode   per-channel direction captured at start (0 increment, 1 decrement)
//   base   per-channel start address, channel i at [i*AW +: AW]
//   len    per-channel beat count, channel i at [i*AW +: AW]
//   bsy    channel i is running or draining its last beat
//   done   one-cycle pulse when channel i's burst completes
//   mem    write port (we/ai/ch out, rdy in)
module mdrv_rr #(
    parameter int NCH = 4,
    parameter int AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    mode,
    input  logic [NCH*AW-1:0] base,
    input  logic [NCH*AW-1:0] len,
    output logic [NCH-1:0]    bsy,
    output logic [NCH-1:0]    done,
    mdrv_rr_if.master         mem
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} st_t;

    st_t           st_q   [NCH];
    st_t           st_n   [NCH];
    logic [AW-1:0] base_q [NCH];
    logic [AW-1:0] base_n [NCH];
    logic [AW-1:0] len_q  [NCH];
    logic [AW-1:0] len_n  [NCH];
    logic [AW-1:0] cnt_q  [NCH];
    logic [AW-1:0] cnt_n  [NCH];
    logic [AW-1:0] addr   [NCH];
    logic [NCH-1:0] mode_q, mode_n;
    logic [NCH-1:0] done_q, done_n;

    logic          we_q, we_n;
    logic [AW-1:0] ai_q, ai_n;
    logic [CW-1:0] ch_q, ch_n;
    logic [CW-1:0] ptr_q, ptr_n;
    logic [CW-1:0] gnt;
    logic          any_run;
    logic          free;
    logic          load;

    // Current address of every channel; wraps modulo 2^AW.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            addr[i] = mode_q[i] ? (base_q[i] - cnt_q[i]) : (base_q[i] + cnt_q[i]);
        end
    end

    // Round-robin: first RUN channel found scanning upward from ptr+1 with wrap.
    always_comb begin
        any_run = 1'b0;
        gnt     = ptr_q;
        for (int k = 1; k <= NCH; k++) begin
            if (!any_run && st_q[(int'(ptr_q) + k) % NCH] == S_RUN) begin
                any_run = 1'b1;
                gnt     = CW'((int'(ptr_q) + k) % NCH);
            end
        end
    end

    // The output slot can take a new beat when empty or being drained this cycle.
    assign free = !we_q || mem.rdy;
    assign load = free && any_run;

    always_comb begin
        st_n   = st_q;
        base_n = base_q;
        len_n  = len_q;
        cnt_n  = cnt_q;
        mode_n = mode_q;
        done_n = '0;
        we_n   = we_q;
        ai_n   = ai_q;
        ch_n   = ch_q;
        ptr_n  = ptr_q;

        for (int i = 0; i < NCH; i++) begin
            case (st_q[i])
                S_IDLE: begin
                    if (start[i]) begin
                        base_n[i] = base[i*AW +: AW];
                        len_n[i]  = len[i*AW +: AW];
                        mode_n[i] = mode[i];
                        cnt_n[i]  = '0;
                        if (len[i*AW +: AW] == '0) begin
                            done_n[i] = 1'b1;
                        end else begin
                            st_n[i] = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (load && gnt == CW'(i)) begin
                        cnt_n[i] = cnt_q[i] + AW'(1);
                        if (cnt_q[i] == len_q[i] - AW'(1)) begin
                            st_n[i] = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Only this channel's last beat can be in the slot while it drains.
                    if (we_q && mem.rdy && ch_q == CW'(i)) begin
                        st_n[i]   = S_IDLE;
                        done_n[i] = 1'b1;
                    end
                end
                default: st_n[i] = S_IDLE;
            endcase
        end

        if (free) begin
            if (any_run) begin
                we_n  = 1'b1;
                ai_n  = addr[gnt];
                ch_n  = gnt;
                ptr_n = gnt;
            end else begin
                we_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]   <= S_IDLE;
                base_q[i] <= '0;
                len_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            mode_q <= '0;
            done_q <= '0;
            we_q   <= 1'b0;
            ai_q   <= '0;
            ch_q   <= '0;
            ptr_q  <= CW'(NCH - 1);
        end else begin
            st_q   <= st_n;
            base_q <= base_n;
            len_q  <= len_n;
            cnt_q  <= cnt_n;
            mode_q <= mode_n;
            done_q <= done_n;
            we_q   <= we_n;
            ai_q   <= ai_n;
            ch_q   <= ch_n;
            ptr_q  <= ptr_n;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            bsy[i] = (st_q[i] != S_IDLE);
        end
    end

    assign done   = done_q;
    assign mem.we = we_q;
    assign mem.ai = ai_q;
    assign mem.ch = ch_q;
endmodule

// File: tb/tb_mdrv_rr.sv
// tb/tb_mdrv_rr.sv - directed self-checking bench for mdrv_rr
module tb_mdrv_rr;
    localparam int NCH = 4;
    localparam int AW  = 8;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    mode;
    logic [NCH*AW-1:0] base;
    logic [NCH*AW-1:0] len;
    logic [NCH-1:0]    bsy;
    logic [NCH-1:0]    done;

    int n_tests;
    int n_fail;

    mdrv_rr_if #(.NCH(NCH), .AW(AW)) mem ();

    mdrv_rr #(.NCH(NCH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .base  (base),
        .len   (len),
        .bsy   (bsy),
        .done  (done),
        .mem   (mem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; all driving and sampling happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic setup(input int c, input logic [AW-1:0] b, input logic [AW-1:0] l, input logic m);
        base[c*AW +: AW] = b;
        len[c*AW +: AW]  = l;
        mode[c]          = m;
    endtask

    task automatic chk_beat(input string tag, input logic [AW-1:0] a, input int c);
        chk({tag, ".we"}, 32'(mem.we), 32'd1);
        chk({tag, ".ai"}, 32'(mem.ai), 32'(a));
        chk({tag, ".ch"}, 32'(mem.ch), 32'(c));
    endtask

    initial begin
        logic [AW-1:0] rr_ai [6];
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = '0;
        mode    = '0;
        base    = '0;
        len     = '0;
        mem.rdy = 1'b1;
        #12;
        chk("rst.we", 32'(mem.we), 32'd0);
        chk("rst.ai", 32'(mem.ai), 32'd0);
        chk("rst.ch", 32'(mem.ch), 32'd0);
        chk("rst.bsy", 32'(bsy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single increment burst.
        setup(0, 8'h10, 8'd4, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        chk("single.bsy0", 32'(bsy), 32'b0001);
        chk("single.we0", 32'(mem.we), 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk_beat("single", AW'(8'h10 + b), 0);
            chk("single.done", 32'(done), 32'd0);
        end
        tick();
        chk("single.we_end", 32'(mem.we), 32'd0);
        chk("single.done_end", 32'(done), 32'b0001);
        chk("single.bsy_end", 32'(bsy), 32'd0);
        tick();
        chk("single.done_off", 32'(done), 32'd0);

        // Two channels interleaved.
        do_reset();
        setup(0, 8'h00, 8'd3, 1'b0);
        setup(1, 8'h80, 8'd3, 1'b0);
        rr_ai[0] = 8'h00; rr_ai[1] = 8'h80; rr_ai[2] = 8'h01;
        rr_ai[3] = 8'h81; rr_ai[4] = 8'h02; rr_ai[5] = 8'h82;
        start = 4'b0011;
        tick();
        start = '0;
        for (int b = 0; b < 6; b++) begin
            tick();
            chk_beat("rr", rr_ai[b], b % 2);
            chk("rr.done", 32'(done), (b == 5) ? 32'b0001 : 32'd0);
        end
        tick();
        chk("rr.done1", 32'(done), 32'b0010);
        chk("rr.we_end", 32'(mem.we), 32'd0);

        // Decrement across zero.
        do_reset();
        setup(2, 8'h01, 8'd3, 1'b1);
        start = 4'b0100;
        tick();
        start = '0;
        tick(); chk_beat("dec0", 8'h01, 2);
        tick(); chk_beat("dec1", 8'h00, 2);
        tick(); chk_beat("dec2", 8'hFF, 2);
        tick();
        chk("dec.done", 32'(done), 32'b0100);
        tick();
        chk("dec.done_off", 32'(done), 32'd0);

        // Back-pressure while 0x11 is presented.
        do_reset();
        setup(0, 8'h10, 8'd4, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        tick(); chk_beat("bp0", 8'h10, 0);
        tick(); chk_beat("bp1", 8'h11, 0);
        mem.rdy = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk_beat("bp_hold", 8'h11, 0);
        end
        mem.rdy = 1'b1;
        tick(); chk_beat("bp2", 8'h12, 0);
        tick(); chk_beat("bp3", 8'h13, 0);
        tick();
        chk("bp.we_end", 32'(mem.we), 32'd0);
        chk("bp.done", 32'(done), 32'b0001);

        // Zero-length start.
        do_reset();
        setup(1, 8'h33, 8'd0, 1'b0);
        start = 4'b0010;
        tick();
        start = '0;
        chk("len0.done", 32'(done), 32'b0010);
        chk("len0.we", 32'(mem.we), 32'd0);
        chk("len0.bsy", 32'(bsy), 32'd0);
        tick();
        chk("len0.done_off", 32'(done), 32'd0);
        chk("len0.we2", 32'(mem.we), 32'd0);

        // Start while running is ignored.
        setup(0, 8'h10, 8'd4, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        tick(); chk_beat("busy0", 8'h10, 0);
        setup(0, 8'h50, 8'd1, 1'b1);
        start = 4'b0001;
        tick(); chk_beat("busy1", 8'h11, 0);
        start = '0;
        tick(); chk_beat("busy2", 8'h12, 0);
        tick(); chk_beat("busy3", 8'h13, 0);
        tick();
        chk("busy.done", 32'(done), 32'b0001);
        chk("busy.we_end", 32'(mem.we), 32'd0);

        // Asynchronous reset mid-burst, then channel 0 wins first again.
        setup(0, 8'h10, 8'd4, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        tick(); chk_beat("mid0", 8'h10, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.we", 32'(mem.we), 32'd0);
        chk("arst.bsy", 32'(bsy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        tick();
        chk("arst.done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        setup(0, 8'h20, 8'd1, 1'b0);
        setup(1, 8'h40, 8'd1, 1'b0);
        start = 4'b0011;
        tick();
        start = '0;
        tick(); chk_beat("post0", 8'h20, 0);
        tick(); chk_beat("post1", 8'h40, 1);
        chk("post.done0", 32'(done), 32'b0001);
        tick();
        chk("post.done1", 32'(done), 32'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end
endmodule
